uart_receiver: RTL and testbench

//  8N1 UART receive path for riscv_virtual_device, the partner of the device's uart_tx output.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart_receiver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding and default bit timing.
// The uart_transmitter uses this package as well, so keep it free of receiver-only items.
package uart_pkg;

  // 100 MHz system clock at 115200 baud.
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous show-ahead FIFO for received bytes.
// The head entry appears on o_rdata without a read request.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // The extra pointer bit tells full from empty when the index bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// show-ahead receive FIFO popped with a valid/ready handshake.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        w_rxs;

  uart_state_e r_state;
  uart_state_e w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        w_push_req;
  logic        w_stop_bad;

  logic        r_frame_err;
  logic        r_overrun;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;

  // Sync flops reset to the idle level so reset itself never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_push_req   = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        w_cnt_next = '0;
        if (w_rxs) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_cnt_next = '0;
        if (!w_rxs) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is no longer low at its midpoint is treated as a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_next = '0;
          if (!w_rxs) begin
            w_state_next = ST_DATA;
            w_idx_next   = '0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rxs, r_shift[7:1]};
          w_idx_next   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop lets a zero-gap start bit be caught.
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            w_push_req   = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_WAIT_IDLE;
      end
    endcase
  end

  assign rx_valid = !w_empty;
  assign w_pop    = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_push_req && w_full && !w_pop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk per bit and a 4-entry FIFO.
// Frames are driven one bit per 16 clocks starting 1 time unit after a rising edge.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;
  int fe_cycles   = 0;
  int ov_cycles   = 0;
  int busy_cycles = 0;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cycles++;
    if (overrun === 1'b1) ov_cycles++;
    if (busy === 1'b1) busy_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    $display("tx byte 0x%02h stop=%0b", b, stop_bit);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(rx_valid), 1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    $display("rx pop 0x%02h (expected 0x%02h)", rx_data, exp);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int b0;
    int fe0;
    int ov0;
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 1);
    rst = 1'b0;
    idle(4);
    check("idle_busy", 32'(busy), 0);

    // 1: timed reception of 0xA5, held until popped.
    idle(4 * CPB);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("t1_valid_early", 32'(rx_valid), 0);
        @(posedge clk);
        #1;
        check("t1_valid_on_time", 32'(rx_valid), 1);
        check("t1_data_on_time", 32'(rx_data), 32'h A5);
      end
    join
    idle(20);
    check("t1_hold_valid", 32'(rx_valid), 1);
    check("t1_hold_data", 32'(rx_data), 32'h A5);
    pop_expect("t1_pop", 8'hA5);
    check("t1_empty", 32'(rx_valid), 0);

    // 2: short low glitch.
    b0 = busy_cycles;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("t2_busy_seen", 32'(busy_cycles > b0), 1);
    check("t2_busy_end", 32'(busy), 0);
    check("t2_valid", 32'(rx_valid), 0);
    check("t2_fe", 32'(fe_cycles), 0);
    check("t2_ov", 32'(ov_cycles), 0);

    // 3: framing error, then a clean byte.
    send_byte(8'h3C, 1'b0);
    check("t3_fe_pulse", 32'(fe_cycles), 1);
    check("t3_busy_line_low", 32'(busy), 1);
    check("t3_no_push", 32'(rx_valid), 0);
    idle(8);
    check("t3_busy_released", 32'(busy), 0);
    send_byte(8'h55, 1'b1);
    idle(4);
    pop_expect("t3_pop", 8'h55);
    check("t3_fe_total", 32'(fe_cycles), 1);

    // 4: overrun on the 5th back-to-back byte.
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    check("t4_ov_before", 32'(ov_cycles), 0);
    send_byte(8'h05, 1'b1);
    check("t4_ov_after", 32'(ov_cycles), 1);
    idle(4);
    for (int i = 1; i <= 4; i++) pop_expect("t4_pop", 8'(i));
    check("t4_empty", 32'(rx_valid), 0);
    check("t4_ov_total", 32'(ov_cycles), 1);

    // 5: reset mid bit 7 of 0x7E with one byte queued.
    send_byte(8'h5A, 1'b1);
    idle(4);
    check("t5_queued", 32'(rx_valid), 1);
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (138) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_valid", 32'(rx_valid), 0);
        check("t5_rst_busy", 32'(busy), 1);
        rst = 1'b0;
      end
    join
    idle(20);
    check("t5_no_byte", 32'(rx_valid), 0);
    check("t5_no_fe", 32'(fe_cycles), 32'(fe0));
    check("t5_no_ov", 32'(ov_cycles), 32'(ov0));
    send_byte(8'h81, 1'b1);
    idle(4);
    pop_expect("t5_pop", 8'h81);
    check("t5_empty", 32'(rx_valid), 0);

    // 6: pop on the exact stop-sample cycle while full.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    ov0 = ov_cycles;
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("t6_head", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    check("t6_no_ov", 32'(ov_cycles), 32'(ov0));
    idle(4);
    pop_expect("t6_pop", 8'h22);
    pop_expect("t6_pop", 8'h33);
    pop_expect("t6_pop", 8'h44);
    pop_expect("t6_pop", 8'h99);
    check("t6_empty", 32'(rx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
